// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for two requesters sharing a 2:1 mux, with a per-grant hold
// limit that forces rotation and a registered mux output with a valid flag.
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic       LAST_A    = 1'b0;
  localparam logic       LAST_B    = 1'b1;

  state_t     state, next_state;
  logic       last, next_last;
  logic [7:0] hold_cnt, next_hold;
  logic       next_sel;
  logic       valid_next;

  always_comb begin
    next_state = state;
    next_last  = last;
    next_sel   = sel;
    next_hold  = hold_cnt;
    valid_next = (gnt_a & req_a) | (gnt_b & req_b);

    case (state)
      IDLE: begin
        if (req_a && req_b)
          next_state = (last == LAST_B) ? GNT_A : GNT_B;
        else if (req_a)
          next_state = GNT_A;
        else if (req_b)
          next_state = GNT_B;
      end
      GNT_A: begin
        if (!req_a)
          next_state = req_b ? GNT_B : IDLE;
        else if (req_b && hold_cnt == HOLD_LAST)
          next_state = GNT_B;
      end
      GNT_B: begin
        if (!req_b)
          next_state = req_a ? GNT_A : IDLE;
        else if (req_a && hold_cnt == HOLD_LAST)
          next_state = GNT_A;
      end
      default: next_state = IDLE;
    endcase

    // The counter restarts on every grant entry and saturates so a late request
    // from the other side rotates on the very next edge.
    if (next_state != state)
      next_hold = 8'd0;
    else if (state != IDLE && hold_cnt < HOLD_LAST)
      next_hold = hold_cnt + 8'd1;

    if (next_state == GNT_A) begin
      next_sel  = 1'b0;
      next_last = LAST_A;
    end else if (next_state == GNT_B) begin
      next_sel  = 1'b1;
      next_last = LAST_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= LAST_B;
      hold_cnt <= 8'd0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      sel      <= 1'b0;
    end else begin
      state    <= next_state;
      last     <= next_last;
      hold_cnt <= next_hold;
      gnt_a    <= (next_state == GNT_A);
      gnt_b    <= (next_state == GNT_B);
      sel      <= next_sel;
    end
  end

  // out_data only captures words that are flagged valid; otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= valid_next;
      if (valid_next)
        out_data <= sel ? b_data : a_data;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: two instances (MAX_HOLD 4 and 1) share inputs and are
// compared every cycle against an owner/run-length reference model.
module tb_mux2_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b;
  logic [7:0] a_data, b_data;

  logic [1:0] gnt_a_v, gnt_b_v, sel_v, out_valid_v;
  logic [7:0] out_data_v [2];

  int tests_run;
  int tests_failed;

  // Reference model: owner 0=none 1=A 2=B, run = cycles spent in current grant.
  int m_hold  [2];
  int m_owner [2];
  int m_last  [2];
  int m_run   [2];
  int m_sel   [2];
  int m_valid [2];
  int m_data  [2];

  mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .a_data(a_data), .b_data(b_data),
    .gnt_a(gnt_a_v[0]), .gnt_b(gnt_b_v[0]), .sel(sel_v[0]),
    .out_data(out_data_v[0]), .out_valid(out_valid_v[0])
  );

  mux2_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .a_data(a_data), .b_data(b_data),
    .gnt_a(gnt_a_v[1]), .gnt_b(gnt_b_v[1]), .sel(sel_v[1]),
    .out_data(out_data_v[1]), .out_valid(out_valid_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0;
      m_last[i]  = 2;
      m_run[i]   = 0;
      m_sel[i]   = 0;
      m_valid[i] = 0;
      m_data[i]  = 0;
    end
  endtask

  task automatic modelEdge(input int i);
    int nxt;
    m_valid[i] = ((m_owner[i] == 1 && req_a) || (m_owner[i] == 2 && req_b)) ? 1 : 0;
    if (m_valid[i] == 1)
      m_data[i] = (m_sel[i] == 1) ? int'(b_data) : int'(a_data);
    nxt = m_owner[i];
    if (m_owner[i] == 0) begin
      if (req_a && req_b) nxt = 3 - m_last[i];
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
    end else begin
      int mine  = (m_owner[i] == 1) ? int'(req_a) : int'(req_b);
      int other = (m_owner[i] == 1) ? int'(req_b) : int'(req_a);
      if (mine == 0)
        nxt = (other == 1) ? 3 - m_owner[i] : 0;
      else if (other == 1 && m_run[i] >= m_hold[i])
        nxt = 3 - m_owner[i];
    end
    if (nxt != m_owner[i]) m_run[i] = (nxt == 0) ? 0 : 1;
    else if (nxt != 0)     m_run[i] = m_run[i] + 1;
    if (nxt != 0) begin
      m_sel[i]  = (nxt == 2) ? 1 : 0;
      m_last[i] = nxt;
    end
    m_owner[i] = nxt;
  endtask

  task automatic checkVal(input string tag, input int i, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s inst%0d observed=%0h expected=%0h", tag, i, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkVal({tag, ".gnt_a"}, i, int'(gnt_a_v[i]), (m_owner[i] == 1) ? 1 : 0);
      checkVal({tag, ".gnt_b"}, i, int'(gnt_b_v[i]), (m_owner[i] == 2) ? 1 : 0);
      checkVal({tag, ".sel"}, i, int'(sel_v[i]), m_sel[i]);
      checkVal({tag, ".out_valid"}, i, int'(out_valid_v[i]), m_valid[i]);
      checkVal({tag, ".out_data"}, i, int'(out_data_v[i]), m_data[i]);
      checkVal({tag, ".onehot"}, i, int'(gnt_a_v[i] & gnt_b_v[i]), 0);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic rb, input logic [7:0] ad,
                               input logic [7:0] bd, input string tag);
    req_a  = ra;
    req_b  = rb;
    a_data = ad;
    b_data = bd;
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_hold[0]    = 4;
    m_hold[1]    = 1;
    modelReset();
    rst_n  = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    a_data = 8'h5A;
    b_data = 8'hC3;
    #12;
    checkOutput("por");
    #8 rst_n = 1'b1;

    // Grant B, then pull reset mid-cycle with no clock edge.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 8'h5A, 8'hC3, "pre_reset");
    checkVal("pre_reset.sel_b", 0, int'(sel_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkVal("async.gnt_a", i, int'(gnt_a_v[i]), 0);
      checkVal("async.gnt_b", i, int'(gnt_b_v[i]), 0);
      checkVal("async.sel", i, int'(sel_v[i]), 0);
      checkVal("async.out_valid", i, int'(out_valid_v[i]), 0);
      checkVal("async.out_data", i, int'(out_data_v[i]), 0);
    end
    modelReset();
    #1 rst_n = 1'b1;

    applyStimulus(1'b1, 1'b1, 8'h5A, 8'hC3, "tie_first");
    checkVal("tie_first.a_wins", 0, int'(gnt_a_v[0]), 1);
    for (int k = 0; k < 11; k++) applyStimulus(1'b1, 1'b1, 8'h5A, 8'hC3, "rotate");
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, 8'h5A, 8'hC3, "idle");

    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b0, 8'h5A, 8'hC3, "single_a");
    checkVal("single_a.data", 0, int'(out_data_v[0]), 8'h5A);
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, 8'h5A, 8'hC3, "release");
    checkVal("release.hold_data", 0, int'(out_data_v[0]), 8'h5A);

    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 8'h5A, 8'hC3, "handoff_pre");
    applyStimulus(1'b0, 1'b1, 8'h5A, 8'hC3, "handoff");
    checkVal("handoff.gnt_b", 0, int'(gnt_b_v[0]), 1);
    applyStimulus(1'b0, 1'b1, 8'h5A, 8'hC3, "handoff_data");
    checkVal("handoff.first_b", 0, int'(out_data_v[0]), 8'hC3);
    applyStimulus(1'b0, 1'b0, 8'h5A, 8'hC3, "handoff_end");

    for (int k = 0; k < 400; k++)
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    8'($urandom), 8'($urandom), "random");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
